// File: rtl/spi_byte_peripheral.sv
// SPI mode-0 MSB-first byte peripheral: oversamples SCK/CS_N/PICO in the clk_i
// domain, shifts tx_byte_i out on POCI and strobes each completed received byte.
module spi_byte_peripheral #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  spi_cs_ni,
  input  logic                  spi_sck_i,
  input  logic                  spi_rx_i,
  output logic                  spi_tx_o,
  input  logic [DATA_WIDTH-1:0] tx_byte_i,
  output logic [DATA_WIDTH-1:0] rx_byte_o,
  output logic                  rx_valid_o
);

  localparam int CNT_W = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] rx_sync;
  logic                   cs_q;
  logic                   sck_q;
  logic [CNT_W-1:0]       bit_cnt;
  logic [DATA_WIDTH-1:0]  rx_shift;
  logic [DATA_WIDTH-1:0]  tx_shift;

  logic cs_s, sck_s, rx_s;
  logic cs_fall, sck_rise, sck_fall;
  logic [DATA_WIDTH-1:0] rx_next;

  assign cs_s     = cs_sync[SYNC_STAGES-1];
  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign rx_s     = rx_sync[SYNC_STAGES-1];
  assign cs_fall  = cs_q & ~cs_s;
  assign sck_rise = ~sck_q & sck_s;
  assign sck_fall = sck_q & ~sck_s;
  assign rx_next  = {rx_shift[DATA_WIDTH-2:0], rx_s};

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cs_sync    <= '1;
      sck_sync   <= '0;
      rx_sync    <= '0;
      cs_q       <= 1'b1;
      sck_q      <= 1'b0;
      bit_cnt    <= '0;
      rx_shift   <= '0;
      tx_shift   <= '0;
      rx_byte_o  <= '0;
      rx_valid_o <= 1'b0;
      spi_tx_o   <= 1'b0;
    end else begin
      cs_sync  <= {cs_sync[SYNC_STAGES-2:0], spi_cs_ni};
      sck_sync <= {sck_sync[SYNC_STAGES-2:0], spi_sck_i};
      rx_sync  <= {rx_sync[SYNC_STAGES-2:0], spi_rx_i};
      cs_q     <= cs_s;
      sck_q    <= sck_s;
      rx_valid_o <= 1'b0;

      // Deselect wins over any coincident SCK edge, discarding the partial byte.
      if (cs_s) begin
        bit_cnt  <= '0;
        rx_shift <= '0;
        spi_tx_o <= 1'b0;
      end else if (cs_fall) begin
        bit_cnt  <= '0;
        tx_shift <= tx_byte_i;
        spi_tx_o <= tx_byte_i[DATA_WIDTH-1];
      end else begin
        if (sck_rise) begin
          rx_shift <= rx_next;
          if (bit_cnt == LAST_BIT) begin
            bit_cnt    <= '0;
            rx_byte_o  <= rx_next;
            rx_valid_o <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end
        if (sck_fall) begin
          // Counter at zero on a falling edge marks the start of the next byte.
          if (bit_cnt != '0) begin
            tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
            spi_tx_o <= tx_shift[DATA_WIDTH-2];
          end else begin
            tx_shift <= tx_byte_i;
            spi_tx_o <= tx_byte_i[DATA_WIDTH-1];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_byte_peripheral.sv
// Directed bench for spi_byte_peripheral: a mode-0 controller model drives the
// pins; a monitor checks every rx_valid_o strobe against an expected queue.
module tb_spi_byte_peripheral;

  localparam int W    = 8;
  localparam int SYNC = 2;
  localparam int HALF = 8;

  logic         clk = 1'b0;
  logic         reset_i;
  logic         spi_cs_ni;
  logic         spi_sck_i;
  logic         spi_rx_i;
  logic         spi_tx_o;
  logic [W-1:0] tx_byte_i;
  logic [W-1:0] rx_byte_o;
  logic         rx_valid_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_rise_cyc = 0;
  int valid_cnt = 0;
  logic prev_valid = 1'b0;
  logic [W-1:0] exp_q[$];

  spi_byte_peripheral #(.DATA_WIDTH(W), .SYNC_STAGES(SYNC)) dut (
    .clk_i      (clk),
    .reset_i    (reset_i),
    .spi_cs_ni  (spi_cs_ni),
    .spi_sck_i  (spi_sck_i),
    .spi_rx_i   (spi_rx_i),
    .spi_tx_o   (spi_tx_o),
    .tx_byte_i  (tx_byte_i),
    .rx_byte_o  (rx_byte_o),
    .rx_valid_o (rx_valid_o)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Scoreboard: each strobe must match the next expected byte, last one cycle,
  // and arrive within SYNC+1 cycles of the final SCK rise.
  always @(negedge clk) begin
    if (rx_valid_o === 1'b1) begin
      valid_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid: got rx_byte 0x%0h with no byte expected", rx_byte_o);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if (rx_byte_o !== e) begin
          errors++;
          $display("FAIL rx_byte: got 0x%0h expected 0x%0h", rx_byte_o, e);
        end
      end
      checks++;
      if (prev_valid) begin
        errors++;
        $display("FAIL valid_width: got 2+ cycle pulse expected 1 cycle");
      end
      checks++;
      if ((cyc - last_rise_cyc) < 1 || (cyc - last_rise_cyc) > SYNC + 1) begin
        errors++;
        $display("FAIL valid_latency: got %0d cycles expected 1..%0d", cyc - last_rise_cyc, SYNC + 1);
      end
    end
    prev_valid = (rx_valid_o === 1'b1);
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cs_low();
    @(negedge clk);
    spi_cs_ni = 1'b0;
    wait_clks(HALF);
  endtask

  task automatic cs_high();
    @(negedge clk);
    spi_cs_ni = 1'b1;
    wait_clks(HALF);
  endtask

  // Mode-0 controller: data changes with SCK low, both sides sample on the rise.
  task automatic send_bits(input logic [W-1:0] mosi, input int nbits, output logic [W-1:0] poci);
    poci = '0;
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      spi_rx_i = mosi[W-1-i];
      wait_clks(HALF);
      spi_sck_i = 1'b1;
      last_rise_cyc = cyc;
      poci = {poci[W-2:0], spi_tx_o};
      wait_clks(HALF);
      spi_sck_i = 1'b0;
    end
    wait_clks(HALF);
  endtask

  typedef struct {
    logic [W-1:0] tx;
    logic [W-1:0] mosi;
    logic [W-1:0] exp_poci;
    logic [W-1:0] exp_rx;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [W-1:0] poci;
    int v0;

    vecs[0] = '{tx: 8'h55, mosi: 8'hAA, exp_poci: 8'h55, exp_rx: 8'hAA};
    vecs[1] = '{tx: 8'h00, mosi: 8'hFF, exp_poci: 8'h00, exp_rx: 8'hFF};
    vecs[2] = '{tx: 8'hFF, mosi: 8'h00, exp_poci: 8'hFF, exp_rx: 8'h00};
    vecs[3] = '{tx: 8'h81, mosi: 8'h7E, exp_poci: 8'h81, exp_rx: 8'h7E};
    vecs[4] = '{tx: 8'hC3, mosi: 8'h3C, exp_poci: 8'hC3, exp_rx: 8'h3C};

    // Reset with CS idle
    reset_i = 1'b1; spi_cs_ni = 1'b1; spi_sck_i = 1'b0; spi_rx_i = 1'b0; tx_byte_i = '0;
    wait_clks(5);
    check("reset_rx_byte", rx_byte_o, 0);
    check("reset_rx_valid", rx_valid_o, 0);
    check("reset_spi_tx", spi_tx_o, 0);
    @(negedge clk); reset_i = 1'b0;
    wait_clks(5);

    // Table-driven single-byte frames
    for (int k = 0; k < 5; k++) begin
      v0 = valid_cnt;
      tx_byte_i = vecs[k].tx;
      exp_q.push_back(vecs[k].exp_rx);
      cs_low();
      send_bits(vecs[k].mosi, W, poci);
      cs_high();
      check($sformatf("vec%0d_poci", k), poci, vecs[k].exp_poci);
      check($sformatf("vec%0d_pulses", k), valid_cnt - v0, 1);
      check($sformatf("vec%0d_rx_byte", k), rx_byte_o, vecs[k].exp_rx);
      check($sformatf("vec%0d_idle_tx", k), spi_tx_o, 0);
    end

    // Back-to-back bytes; tx_byte_i changes mid-way through byte 1
    begin
      logic [W-1:0] poci2;
      v0 = valid_cnt;
      tx_byte_i = 8'hA5;
      exp_q.push_back(8'h12);
      exp_q.push_back(8'h34);
      fork
        begin wait_clks(HALF * 2 * 4 + HALF); tx_byte_i = 8'h3C; end
      join_none
      cs_low();
      send_bits(8'h12, W, poci);
      check("b2b_rx_byte1", rx_byte_o, 8'h12);
      send_bits(8'h34, W, poci2);
      cs_high();
      check("b2b_poci1", poci, 8'hA5);
      check("b2b_poci2", poci2, 8'h3C);
      check("b2b_pulses", valid_cnt - v0, 2);
      check("b2b_rx_byte2", rx_byte_o, 8'h34);
    end

    // Abort after 5 bits, then a clean byte
    v0 = valid_cnt;
    tx_byte_i = 8'h99;
    cs_low();
    send_bits(8'h5A, 5, poci);
    cs_high();
    check("abort_pulses", valid_cnt - v0, 0);
    check("abort_rx_byte_held", rx_byte_o, 8'h34);
    check("abort_spi_tx", spi_tx_o, 0);
    exp_q.push_back(8'hC3);
    cs_low();
    send_bits(8'hC3, W, poci);
    cs_high();
    check("after_abort_pulses", valid_cnt - v0, 1);
    check("after_abort_rx_byte", rx_byte_o, 8'hC3);

    // Reset mid-byte
    tx_byte_i = 8'hFF;
    cs_low();
    send_bits(8'hE7, 3, poci);
    @(negedge clk);
    reset_i = 1'b1;
    wait_clks(2);
    check("midreset_rx_byte", rx_byte_o, 0);
    check("midreset_rx_valid", rx_valid_o, 0);
    check("midreset_spi_tx", spi_tx_o, 0);
    spi_cs_ni = 1'b1;
    wait_clks(2);
    reset_i = 1'b0;
    wait_clks(HALF);
    v0 = valid_cnt;
    exp_q.push_back(8'h81);
    cs_low();
    send_bits(8'h81, W, poci);
    cs_high();
    check("after_reset_pulses", valid_cnt - v0, 1);
    check("after_reset_rx_byte", rx_byte_o, 8'h81);

    // SCK noise while deselected, then a real byte
    v0 = valid_cnt;
    for (int i = 0; i < 12; i++) begin
      spi_rx_i = i[0];
      wait_clks(HALF);
      spi_sck_i = ~spi_sck_i;
    end
    spi_sck_i = 1'b0;
    wait_clks(HALF);
    check("noise_pulses", valid_cnt - v0, 0);
    check("noise_rx_byte_held", rx_byte_o, 8'h81);
    exp_q.push_back(8'hF0);
    cs_low();
    send_bits(8'hF0, W, poci);
    cs_high();
    check("noise_then_pulses", valid_cnt - v0, 1);
    check("noise_then_rx_byte", rx_byte_o, 8'hF0);

    wait_clks(4);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_byte_peripheral.md
Name: spi_byte_peripheral

Overview:
- SPI mode-0 (CPOL=0, CPHA=0), MSB-first, byte-oriented peripheral (target) port.
- Oversamples an external controller's SCK/CS_N/PICO in the local clock domain, shifts out a parallel transmit byte on POCI, and assembles received bits into a byte.
- Emits a one-cycle valid strobe per completed received byte.
- Sits between the board SPI pins and the register/bus bridge that consumes command bytes.

Parameters:
- DATA_WIDTH, 8, bits per SPI frame word.
- SYNC_STAGES, 2, flip-flop stages in each pin input synchronizer (minimum 2).

Ports:
- clk_i  input  1  system clock; must be at least 8x the SCK frequency.
- reset_i  input  1  asynchronous, active-high reset.
- spi_cs_ni  input  1  chip select, active low, asynchronous to clk_i.
- spi_sck_i  input  1  SPI clock from controller, asynchronous to clk_i.
- spi_rx_i  input  1  PICO serial data in.
- spi_tx_o  output  1  POCI serial data out.
- tx_byte_i  input  DATA_WIDTH  byte to transmit; sampled at each byte start.
- rx_byte_o  output  DATA_WIDTH  last completely received byte.
- rx_valid_o  output  1  one-clk_i pulse when rx_byte_o has just been updated.

Behaviour:
- Single clock domain clk_i. reset_i is asynchronous and active-high.
- Reset values:
  - rx_byte_o=0, rx_valid_o=0, spi_tx_o=0.
  - Bit counter=0, shift registers=0.
  - CS synchronizer presets to 1; SCK and RX synchronizers preset to 0.
- Synchronization: spi_cs_ni, spi_sck_i and spi_rx_i each pass through SYNC_STAGES flops. A further registered copy of SCK and CS provides edge detection. All logic below uses the synchronized signals only.
- Idle state (CS high): bit counter held at 0, rx_valid_o=0, spi_tx_o=0.
- CS falling edge (select):
  - tx shift register <= tx_byte_i.
  - spi_tx_o <= tx_byte_i[DATA_WIDTH-1] on the next clk_i.
  - Bit counter <= 0.
- SCK rising edge while selected:
  - rx shift register <= {rx_shift[DATA_WIDTH-2:0], synced spi_rx_i}.
  - Bit counter increments.
- Byte completion, on the rising edge that makes the counter reach DATA_WIDTH:
  - rx_byte_o <= full shifted byte including the bit just sampled.
  - rx_valid_o=1 for exactly one clk_i cycle.
  - Counter wraps to 0.
- SCK falling edge while selected:
  - If counter != 0: tx shift register shifts left and spi_tx_o <= next bit.
  - If counter == 0 (byte boundary): reload tx shift register from tx_byte_i and drive its MSB. This supports back-to-back bytes without releasing CS.
- Latency:
  - rx_valid_o asserts SYNC_STAGES+1 clk_i cycles after the final SCK rising edge at the pin.
  - spi_tx_o updates SYNC_STAGES+1 cycles after an SCK falling edge or CS falling edge at the pin.
  - The controller must keep each SCK half-period at least SYNC_STAGES+2 clk_i periods.
- Between strobes, rx_byte_o holds its value; it is unchanged by CS release or incomplete bytes.
- CS rising mid-byte (abort): counter cleared, partial rx bits discarded, no rx_valid_o, spi_tx_o=0.
- Simultaneous CS rise and final SCK rise in the same clk_i cycle: CS takes priority and the byte is discarded.
- SCK edges while CS is high are ignored.
- tx_byte_i changes mid-byte do not affect the byte in flight.
- reset_i asserted mid-byte: immediate return to reset values; the byte in flight is lost. After reset release, the first valid byte needs a fresh CS falling edge.

Test Plan:
- Reset: assert reset_i with CS high -> rx_byte_o=0x00, rx_valid_o=0, spi_tx_o=0.
- Single byte: tx_byte_i=0x55; controller lowers CS, sends 0xAA mode-0 MSB-first, raises CS.
  - Controller samples POCI 0,1,0,1,0,1,0,1 (0x55).
  - rx_byte_o=0xAA with exactly one rx_valid_o pulse, within SYNC_STAGES+1 cycles of the 8th SCK rise.
- Back-to-back: CS held low, controller sends 0x12 then 0x34; tx_byte_i=0xA5 for byte 1, changed to 0x3C before byte 2 starts.
  - Two rx_valid_o pulses, rx_byte_o=0x12 then 0x34.
  - POCI returns 0xA5 then 0x3C.
- Abort: CS rises after 5 SCK cycles -> no rx_valid_o, rx_byte_o keeps its previous value. Next full byte 0xC3 is received correctly.
- Reset mid-byte: reset_i pulses after 3 bits -> outputs return to reset values. A new CS cycle sending 0x81 yields rx_byte_o=0x81.
- Noise: toggle SCK while CS is high, then send 0xF0 -> only one valid pulse, rx_byte_o=0xF0.
